// File: rtl/ad9253_frame_align.sv
// Frame aligner: slips bitslip until the FCO word matches FRAME_PATTERN, then holds lock and watches for loss.
// Latency: align_start to aligned is 1+SETTLE_CYC+CHECK_CYC cycles with no slip; no backpressure, runs every frame clock.
module ad9253_frame_align #(
    parameter int unsigned        DATA_WD       = 8,
    parameter logic [DATA_WD-1:0] FRAME_PATTERN = 8'hF0,
    parameter int unsigned        SETTLE_CYC    = 4,
    parameter int unsigned        CHECK_CYC     = 16,
    parameter int unsigned        LOSS_CNT      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               align_start,
    input  logic [DATA_WD-1:0] frame_din,
    output logic               slip,
    output logic               aligned,
    output logic               align_err,
    output logic [5:0]         slip_pos
);

    localparam int unsigned TRY_W   = $clog2(DATA_WD + 1);
    localparam int unsigned WAIT_W  = $clog2(SETTLE_CYC + 1);
    localparam int unsigned MATCH_W = $clog2(CHECK_CYC + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

    localparam logic [TRY_W-1:0]   TRY_MAX    = TRY_W'(DATA_WD);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SETTLE_CYC - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(CHECK_CYC - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);
    localparam logic [5:0]         POS_LAST   = 6'(DATA_WD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_LOCKED, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [5:0]         slip_pos_q, slip_pos_d;
    logic               slip_q, slip_d;
    logic               aligned_q, aligned_d;
    logic               align_err_q, align_err_d;
    logic               match;

    assign match = (frame_din == FRAME_PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // align_start overrides every other transition, including leaving LOCKED or FAIL
    always_comb begin
        state_d = state_q;
        if (align_start) begin
            state_d = S_SETTLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_IDLE;
                S_SETTLE: if (wait_cnt_q == WAIT_LAST) state_d = S_CHECK;
                S_CHECK: begin
                    if (match) begin
                        if (match_cnt_q == MATCH_LAST) state_d = S_LOCKED;
                    end else if (tries_q == TRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_SLIP;
                    end
                end
                S_SLIP:   state_d = S_SETTLE;
                S_LOCKED: if (!match && miss_cnt_q == MISS_LAST) state_d = S_SETTLE;
                S_FAIL:   state_d = S_FAIL;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered copies of the state being entered
    always_comb begin
        slip_d      = (state_d == S_SLIP);
        aligned_d   = (state_d == S_LOCKED);
        align_err_d = (state_d == S_FAIL);
    end

    always_comb begin
        tries_d     = tries_q;
        slip_pos_d  = slip_pos_q;
        wait_cnt_d  = '0;
        match_cnt_d = '0;
        miss_cnt_d  = '0;
        if (align_start || state_q == S_LOCKED) begin
            tries_d = '0;
        end else if (state_d == S_SLIP) begin
            tries_d = tries_q + 1'b1;
        end
        if (state_d == S_SLIP) begin
            slip_pos_d = (slip_pos_q == POS_LAST) ? 6'd0 : slip_pos_q + 6'd1;
        end
        if (!align_start && state_q == S_SETTLE && state_d == S_SETTLE) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (!align_start && state_q == S_CHECK && state_d == S_CHECK) begin
            match_cnt_d = match_cnt_q + 1'b1;
        end
        if (!align_start && state_q == S_LOCKED && state_d == S_LOCKED && !match) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries_q     <= '0;
            wait_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            slip_pos_q  <= '0;
            slip_q      <= 1'b0;
            aligned_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            tries_q     <= tries_d;
            wait_cnt_q  <= wait_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            slip_pos_q  <= slip_pos_d;
            slip_q      <= slip_d;
            aligned_q   <= aligned_d;
            align_err_q <= align_err_d;
        end
    end

    assign slip      = slip_q;
    assign aligned   = aligned_q;
    assign align_err = align_err_q;
    assign slip_pos  = slip_pos_q;

endmodule

// File: tb/tb_ad9253_frame_align.sv
// Directed bench for ad9253_frame_align with a bitslip model feeding rotated FCO words back.
module tb_ad9253_frame_align;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       align_start;
    logic [7:0] frame_din;
    logic       slip;
    logic       aligned;
    logic       align_err;
    logic [5:0] slip_pos;

    int checks   = 0;
    int failures = 0;

    int offset = 0;
    bit bad    = 1'b0;
    int nslip, p1, p2;

    int    exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    ad9253_frame_align dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .align_start (align_start),
        .frame_din   (frame_din),
        .slip        (slip),
        .aligned     (aligned),
        .align_err   (align_err),
        .slip_pos    (slip_pos)
    );

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        int          s;
        logic [15:0] t;
        s = ((k % 8) + 8) % 8;
        t = {v, v} << s;
        return t[15:8];
    endfunction

    // Bitslip model: slip count reaches the data two cycles after the pulse is sampled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nslip <= 0;
            p1    <= 0;
            p2    <= 0;
        end else begin
            if (slip) nslip <= nslip + 1;
            p1 <= nslip;
            p2 <= p1;
        end
    end

    assign frame_din = bad ? 8'h00 : rotl(8'hF0, offset - p2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_search(input int limit, output int cyc, output int nsl, output int mingap);
        int last;
        align_start = 1'b1;
        cyc = 0; nsl = 0; mingap = 1000; last = -1000;
        do begin
            tick();
            cyc++;
            align_start = 1'b0;
            if (slip) begin
                nsl++;
                if (cyc - last < mingap) mingap = cyc - last;
                last = cyc;
            end
        end while (!aligned && !align_err && cyc < limit);
        chk("search_done", {31'd0, aligned | align_err}, 32'd1);
    endtask

    initial begin
        int cyc, nsl, mingap, any_slip;
        rst_n = 1'b0;
        align_start = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {23'd0, slip, aligned, align_err, slip_pos}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_outputs", {23'd0, slip, aligned, align_err, slip_pos}, 32'd0);

        // 1: already aligned
        offset = 0;
        sb_push("t1_latency", 21);
        sb_push("t1_slips", 0);
        sb_push("t1_pos", 0);
        run_search(100, cyc, nsl, mingap);
        sb_pop(cyc);
        sb_pop(nsl);
        sb_pop(slip_pos);

        // 2: three positions off
        offset = 3;
        sb_push("t2_slips", 3);
        sb_push("t2_aligned", 1);
        sb_push("t2_pos", ((offset % 8) + 8) % 8);
        sb_push("t2_err", 0);
        run_search(300, cyc, nsl, mingap);
        sb_pop(nsl);
        sb_pop(aligned);
        sb_pop(slip_pos);
        sb_pop(align_err);
        chk("t2_slip_gap_ge5", {31'd0, mingap >= 5}, 32'd1);

        // 3: pattern never appears
        bad = 1'b1;
        sb_push("t3_slips", 8);
        sb_push("t3_err", 1);
        sb_push("t3_aligned", 0);
        sb_push("t3_pos", nslip % 8);
        run_search(400, cyc, nsl, mingap);
        sb_pop(nsl);
        sb_pop(align_err);
        sb_pop(aligned);
        sb_pop(slip_pos);

        // 4: relock, then miss filtering and loss of lock
        bad = 1'b0;
        sb_push("t4_relock_slips", 0);
        sb_push("t4_relock_err", 0);
        run_search(100, cyc, nsl, mingap);
        sb_pop(nsl);
        sb_pop(align_err);
        bad = 1'b1; repeat (3) tick();
        bad = 1'b0; tick();
        bad = 1'b1; repeat (3) tick();
        chk("t4_three_misses_hold", {31'd0, aligned}, 32'd1);
        bad = 1'b0; tick();
        bad = 1'b1; repeat (3) tick();
        chk("t4_third_of_four_hold", {31'd0, aligned}, 32'd1);
        tick();
        chk("t4_fourth_miss_drop", {31'd0, aligned}, 32'd0);
        bad = 1'b0;
        cyc = 0; nsl = 0;
        while (!aligned && cyc < 100) begin
            tick();
            cyc++;
            if (slip) nsl++;
        end
        chk("t4_research_cycles", cyc, 32'd20);
        chk("t4_research_no_slip", nsl, 32'd0);

        // 5a: restart during the settle after the second slip
        bad = 1'b1;
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        cyc = 0; nsl = 0;
        while (nsl < 2 && cyc < 200) begin
            tick();
            cyc++;
            if (slip) nsl++;
        end
        chk("t5_two_slips_seen", nsl, 32'd2);
        repeat (2) tick();
        sb_push("t5_full_search_slips", 8);
        sb_push("t5_err", 1);
        run_search(400, cyc, nsl, mingap);
        sb_pop(nsl);
        sb_pop(align_err);

        // 5b: restart out of FAIL
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        chk("t5_err_cleared", {31'd0, align_err}, 32'd0);
        any_slip = slip;
        repeat (3) begin
            tick();
            any_slip = any_slip | slip;
        end
        chk("t5_no_slip_after_restart", any_slip, 32'd0);

        // 6: asynchronous reset mid-check
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        offset = 5;
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        cyc = 0; nsl = 0;
        while (nsl < 5 && cyc < 300) begin
            tick();
            cyc++;
            if (slip) nsl++;
        end
        repeat (10) tick();
        sb_push("t6_pos_before_reset", 5);
        sb_pop(slip_pos);
        chk("t6_in_check_not_locked", {31'd0, aligned}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset_outputs", {23'd0, slip, aligned, align_err, slip_pos}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_pos_after_release", slip_pos, 32'd0);
        chk("t6_idle_after_release", {31'd0, aligned | slip | align_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
